// File: rtl/axi_skidbuffer_pkg.sv
// Shared constants and types for the AXI-stream skid buffer.
package axi_skidbuffer_pkg;

    // Buffering mode selected by axi_skidbuffer's MODE parameter.
    localparam int MODE_PASS = 0;
    localparam int MODE_FWD  = 1;
    localparam int MODE_BWD  = 2;
    localparam int MODE_FULL = 3;

    // Which kind of register slice a single axi_skid_stage implements.
    typedef enum logic {
        StageFwd = 1'b0,
        StageBwd = 1'b1
    } stage_e;

endpackage

// File: rtl/axi_skid_stage.sv
// One register slice of the skid buffer: a forward (output-registered) or a
// backward (ready-registered, 1-entry skid) stage, chosen by Kind.
module axi_skid_stage
    import axi_skidbuffer_pkg::*;
#(
    parameter int unsigned DW   = 8,
    parameter stage_e      Kind = StageFwd
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i
);

    if (Kind == StageFwd) begin : g_fwd
        logic          valid_q, valid_d;
        logic [DW-1:0] data_q, data_d;

        // The register can take a word if it is empty or draining this edge.
        assign s_ready_o = ~valid_q | m_ready_i;
        assign m_valid_o = valid_q;
        assign m_data_o  = data_q;

        // Next state: load on upstream transfer, else empty on downstream transfer.
        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (s_valid_i && s_ready_o) begin
                valid_d = 1'b1;
                data_d  = s_data_i;
            end else if (m_ready_i) begin
                valid_d = 1'b0;
            end
        end

        // Output register with synchronous active-low reset.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end
    end else begin : g_bwd
        logic          skid_valid_q, skid_valid_d;
        logic [DW-1:0] skid_data_q, skid_data_d;

        // Ready comes straight from a flop; the skid entry has priority at the output.
        assign s_ready_o = ~skid_valid_q;
        assign m_valid_o = s_valid_i | skid_valid_q;
        assign m_data_o  = skid_valid_q ? skid_data_q : s_data_i;

        // Next state: park an accepted word when downstream stalls, drop it once it drains.
        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_data_d  = skid_data_q;
            if (m_ready_i) begin
                skid_valid_d = 1'b0;
            end else if (s_valid_i && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_data_i;
            end
        end

        // Skid register with synchronous active-low reset.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                skid_valid_q <= 1'b0;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_data_q  <= skid_data_d;
            end
        end
    end

endmodule

// File: rtl/axi_skidbuffer.sv
// AXI-stream skid buffer: pass-through, forward, backward or fully registered.
module axi_skidbuffer
    import axi_skidbuffer_pkg::*;
#(
    parameter int DW   = 8,
    parameter int MODE = MODE_FWD
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    if (DW < 1) begin : g_bad_dw
        $error("axi_skidbuffer: DW must be at least 1, got %0d", DW);
    end

    if (MODE == MODE_PASS) begin : g_pass
        // No storage: clock and reset are intentionally left unconnected.
        logic unused_clk_rst;
        assign unused_clk_rst = i_clk ^ i_resetn;

        assign m_valid = s_valid;
        assign m_data  = s_data;
        assign s_ready = m_ready;
    end else if (MODE == MODE_FWD) begin : g_fwd
        axi_skid_stage #(
            .DW   (DW),
            .Kind (StageFwd)
        ) u_fwd (
            .clk_i     (i_clk),
            .rst_ni    (i_resetn),
            .s_data_i  (s_data),
            .s_valid_i (s_valid),
            .s_ready_o (s_ready),
            .m_data_o  (m_data),
            .m_valid_o (m_valid),
            .m_ready_i (m_ready)
        );
    end else if (MODE == MODE_BWD) begin : g_bwd
        axi_skid_stage #(
            .DW   (DW),
            .Kind (StageBwd)
        ) u_bwd (
            .clk_i     (i_clk),
            .rst_ni    (i_resetn),
            .s_data_i  (s_data),
            .s_valid_i (s_valid),
            .s_ready_o (s_ready),
            .m_data_o  (m_data),
            .m_valid_o (m_valid),
            .m_ready_i (m_ready)
        );
    end else if (MODE == MODE_FULL) begin : g_full
        // Backward stage faces upstream, forward stage faces downstream.
        logic [DW-1:0] mid_data;
        logic          mid_valid;
        logic          mid_ready;

        axi_skid_stage #(
            .DW   (DW),
            .Kind (StageBwd)
        ) u_bwd (
            .clk_i     (i_clk),
            .rst_ni    (i_resetn),
            .s_data_i  (s_data),
            .s_valid_i (s_valid),
            .s_ready_o (s_ready),
            .m_data_o  (mid_data),
            .m_valid_o (mid_valid),
            .m_ready_i (mid_ready)
        );

        axi_skid_stage #(
            .DW   (DW),
            .Kind (StageFwd)
        ) u_fwd (
            .clk_i     (i_clk),
            .rst_ni    (i_resetn),
            .s_data_i  (mid_data),
            .s_valid_i (mid_valid),
            .s_ready_o (mid_ready),
            .m_data_o  (m_data),
            .m_valid_o (m_valid),
            .m_ready_i (m_ready)
        );
    end else begin : g_bad_mode
        $error("axi_skidbuffer: unsupported MODE %0d", MODE);
    end

endmodule

// File: tb/tb_axi_skidbuffer.sv
// Bench for axi_skidbuffer: all four modes side by side on shared stimulus,
// directed vector table plus randomized traffic against a queue-based model.
module tb_axi_skidbuffer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       s_valid = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] s_data = 8'h00;

    logic       s_ready_w [4];
    logic       m_valid_w [4];
    logic [7:0] m_data_w  [4];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axi_skidbuffer #(
            .DW   (8),
            .MODE (g)
        ) u_dut (
            .i_clk    (clk),
            .i_resetn (rstn),
            .s_data   (s_data),
            .s_valid  (s_valid),
            .s_ready  (s_ready_w[g]),
            .m_data   (m_data_w[g]),
            .m_valid  (m_valid_w[g]),
            .m_ready  (m_ready)
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int m, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s mode=%0d t=%0t got=%0h want=%0h", name, m, $time, got, want);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge; outputs settle before the next.
    task automatic drive(input bit r, input bit sv, input logic [7:0] sd, input bit mr);
        @(posedge clk);
        #1;
        rstn    = r;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         mode;
        bit         rstn;
        bit         sv;
        logic [7:0] sd;
        bit         mr;
        bit         chk;
        bit         exp_sr;
        bit         exp_mv;
        bit         chk_d;
        logic [7:0] exp_md;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(int mode, bit r, bit sv, logic [7:0] sd, bit mr, bit c,
                                 bit sr, bit mv, bit cd, logic [7:0] md);
        vec_t v;
        v.mode = mode; v.rstn = r; v.sv = sv; v.sd = sd; v.mr = mr;
        v.chk = c; v.exp_sr = sr; v.exp_mv = mv; v.chk_d = cd; v.exp_md = md;
        return v;
    endfunction

    task automatic add_reset();
        vecs.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mkv(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00));
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  sent [4][1024];
    int unsigned wr [4];
    int unsigned rd [4];
    bit          prev_stall [4];
    logic [7:0]  prev_md [4];

    function automatic int unsigned capacity(int m);
        case (m)
            0:       return 0;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    task automatic model_clear();
        for (int m = 0; m < 4; m++) begin
            wr[m] = 0;
            rd[m] = 0;
            prev_stall[m] = 1'b0;
            prev_md[m] = 8'h00;
        end
    endtask

    // Compare every mode against its occupancy rules, then advance the model.
    task automatic model_step();
        for (int m = 0; m < 4; m++) begin
            int unsigned stored;
            bit          want_mv, want_sr;
            stored = wr[m] - rd[m];
            case (m)
                0: begin want_mv = s_valid;                   want_sr = m_ready; end
                1: begin want_mv = (stored > 0);              want_sr = (stored == 0) || m_ready; end
                2: begin want_mv = s_valid || (stored > 0);   want_sr = (stored == 0); end
                default: begin want_mv = (stored > 0);        want_sr = (stored < capacity(m)); end
            endcase
            chk("rand_m_valid", m, 32'(m_valid_w[m]), 32'(want_mv));
            chk("rand_s_ready", m, 32'(s_ready_w[m]), 32'(want_sr));
            if (m != 0 && prev_stall[m]) begin
                chk("hold_valid", m, 32'(m_valid_w[m]), 32'd1);
                chk("hold_data", m, 32'(m_data_w[m]), 32'(prev_md[m]));
            end
            if (s_valid && s_ready_w[m]) begin
                sent[m][wr[m] % 1024] = s_data;
                wr[m]++;
            end
            if (m_valid_w[m] && m_ready) begin
                if (rd[m] < wr[m]) begin
                    chk("order_data", m, 32'(m_data_w[m]), 32'(sent[m][rd[m] % 1024]));
                    rd[m]++;
                end else begin
                    chk("spurious_out", m, 32'd1, 32'd0);
                end
            end
            if (wr[m] - rd[m] > capacity(m)) chk("occupancy", m, wr[m] - rd[m], capacity(m));
            prev_stall[m] = m_valid_w[m] && !m_ready;
            prev_md[m]    = m_data_w[m];
        end
    endtask

    task automatic rand_cycle(input bit sv, input bit mr);
        drive(1'b1, sv, 8'($urandom), mr);
        model_step();
    endtask

    initial begin
        // MODE 1 streaming with m_ready high (also a MODE 0 pass-through sample).
        add_reset();
        vecs.push_back(mkv(1, 1, 1, 8'h11, 1, 1, 1, 0, 1, 8'h00));
        vecs.push_back(mkv(1, 1, 1, 8'h22, 1, 1, 1, 1, 1, 8'h11));
        vecs.push_back(mkv(1, 1, 1, 8'h33, 1, 1, 1, 1, 1, 8'h22));
        vecs.push_back(mkv(1, 1, 0, 8'h00, 1, 1, 1, 1, 1, 8'h33));
        vecs.push_back(mkv(1, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00));
        vecs.push_back(mkv(0, 1, 1, 8'h5C, 0, 1, 0, 1, 1, 8'h5C));
        // MODE 2 skid absorbs a stalled word.
        add_reset();
        vecs.push_back(mkv(2, 1, 1, 8'hA5, 0, 1, 1, 1, 1, 8'hA5));
        vecs.push_back(mkv(2, 1, 0, 8'h00, 0, 1, 0, 1, 1, 8'hA5));
        vecs.push_back(mkv(2, 1, 0, 8'h00, 1, 1, 0, 1, 1, 8'hA5));
        vecs.push_back(mkv(2, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00));
        // MODE 3 fills both entries, third word waits.
        add_reset();
        vecs.push_back(mkv(3, 1, 1, 8'h01, 0, 1, 1, 0, 0, 8'h00));
        vecs.push_back(mkv(3, 1, 1, 8'h02, 0, 1, 1, 1, 1, 8'h01));
        vecs.push_back(mkv(3, 1, 1, 8'h03, 0, 1, 0, 1, 1, 8'h01));
        vecs.push_back(mkv(3, 1, 1, 8'h03, 1, 1, 0, 1, 1, 8'h01));
        vecs.push_back(mkv(3, 1, 1, 8'h03, 1, 1, 1, 1, 1, 8'h02));
        vecs.push_back(mkv(3, 1, 0, 8'h00, 1, 1, 1, 1, 1, 8'h03));
        vecs.push_back(mkv(3, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00));
        // Reset while a word is stored: it must vanish.
        add_reset();
        vecs.push_back(mkv(2, 1, 1, 8'h5A, 0, 1, 1, 1, 1, 8'h5A));
        vecs.push_back(mkv(2, 0, 1, 8'h77, 0, 0, 0, 0, 0, 8'h00));
        vecs.push_back(mkv(2, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00));
        vecs.push_back(mkv(3, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00));
        vecs.push_back(mkv(1, 1, 0, 8'h00, 1, 1, 1, 0, 1, 8'h00));
        vecs.push_back(mkv(2, 1, 0, 8'h00, 1, 1, 1, 0, 0, 8'h00));

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rstn, v.sv, v.sd, v.mr);
            if (v.chk) begin
                chk($sformatf("vec%0d_s_ready", i), v.mode, 32'(s_ready_w[v.mode]), 32'(v.exp_sr));
                chk($sformatf("vec%0d_m_valid", i), v.mode, 32'(m_valid_w[v.mode]), 32'(v.exp_mv));
                if (v.chk_d)
                    chk($sformatf("vec%0d_m_data", i), v.mode, 32'(m_data_w[v.mode]),
                        32'(v.exp_md));
            end
        end

        // Randomized traffic against the model.
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        model_clear();
        for (int i = 0; i < 300; i++) rand_cycle(1'($urandom), 1'($urandom_range(0, 3) != 0));
        for (int i = 0; i < 60; i++) rand_cycle(1'(i % 2), 1'((i / 3) % 2));
        for (int i = 0; i < 40; i++) rand_cycle(1'b1, 1'(i % 2));
        for (int i = 0; i < 40; i++) rand_cycle(1'(i % 2), 1'b1);
        // Mid-stream reset with random traffic, then resume.
        for (int i = 0; i < 20; i++) rand_cycle(1'b1, 1'b0);
        drive(1'b0, 1'b1, 8'hEE, 1'b1);
        model_clear();
        for (int i = 0; i < 100; i++) rand_cycle(1'($urandom), 1'($urandom));
        for (int i = 0; i < 6; i++) rand_cycle(1'b0, 1'b1);
        for (int m = 0; m < 4; m++) begin
            chk("drained", m, wr[m] - rd[m], 32'd0);
            chk("m_valid_idle", m, 32'(m_valid_w[m]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
